// File: rtl/pista_tela_colisao_if.sv
// Track-row stream and LED-matrix bundle for the screen/collision block.
// The master side feeds track rows and car buttons and observes the matrix
// and game status; the slave side is the screen/collision block.
interface pista_tela_colisao_if;
    logic [7:0] ROW_IN;
    logic       ROW_VALID;
    logic       CAR_LEFT;
    logic       CAR_RIGHT;
    logic [7:0] LIN;
    logic [7:0] COL;
    logic       CRASH;
    logic [1:0] LIVES_LEFT;
    logic [7:0] SCORE;
    logic       GAME_OVER;

    modport master (
        output ROW_IN,
        output ROW_VALID,
        output CAR_LEFT,
        output CAR_RIGHT,
        input  LIN,
        input  COL,
        input  CRASH,
        input  LIVES_LEFT,
        input  SCORE,
        input  GAME_OVER
    );

    modport slave (
        input  ROW_IN,
        input  ROW_VALID,
        input  CAR_LEFT,
        input  CAR_RIGHT,
        output LIN,
        output COL,
        output CRASH,
        output LIVES_LEFT,
        output SCORE,
        output GAME_OVER
    );
endinterface

// File: rtl/pista_tela_colisao.sv
// Screen buffer, car overlay, collision/lives/score keeping and row-scan
// driver for an 8x8 LED matrix racing game. Track rows scroll in at buf[0]
// and reach the car row buf[7] eight strobes later.
module pista_tela_colisao #(
    parameter int LIVES      = 3,
    parameter int HIT_CYCLES = 16,
    parameter int SCAN_DIV   = 1,
    parameter int CAR_START  = 3
) (
    input  logic                 CLK,
    input  logic                 RESET,
    pista_tela_colisao_if.slave  bus
);

    localparam int HW = $clog2(HIT_CYCLES) + 1;
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [HW-1:0] HIT_LAST   = HW'(HIT_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
    localparam logic [2:0]    CAR_INIT   = 3'(CAR_START);
    localparam logic [1:0]    LIVES_INIT = 2'(LIVES);

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        HIT  = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t          state_reg;
    logic [HW-1:0]   hit_cnt_reg;
    logic            crash_reg;
    logic [1:0]      lives_reg;
    logic            game_over_reg;
    logic [7:0]      score_reg;
    logic [2:0]      car_pos_reg;
    logic [7:0]      row_buf_reg  [8];
    logic [7:0]      row_buf_next [8];
    logic [DW-1:0]   div_reg;
    logic [2:0]      scan_reg;
    logic [7:0]      lin_reg;
    logic [7:0]      col_reg;

    logic            is_play;
    logic            is_hit;
    logic            is_over;
    logic            hit_now;
    logic            hit_exit;
    logic            shift_en;
    logic            car_visible;
    logic [7:0]      car_mask;
    logic [7:0]      scan_row;
    logic [7:0]      overlay;

    // Decode of the current game phase and the per-cycle events derived from it
    always_comb begin
        is_play     = (state_reg == PLAY);
        is_hit      = (state_reg == HIT);
        is_over     = (state_reg == OVER);
        // Collision looks only at registered buffer and car position
        hit_now     = is_play && row_buf_reg[7][car_pos_reg];
        hit_exit    = is_hit && (hit_cnt_reg == HIT_LAST);
        // Track keeps scrolling during the crash animation, never after game over
        shift_en    = bus.ROW_VALID && (is_play || is_hit);
        // Car blinks while crashed, steady otherwise
        car_visible = is_play || is_over || (is_hit && hit_cnt_reg[2]);
        scan_row    = row_buf_reg[scan_reg];
    end

    // One-hot column mask of the car, built bit by bit
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_car_mask
            assign car_mask[gi] = (car_pos_reg == 3'(gi));
        end
    endgenerate

    assign overlay = ((scan_reg == 3'd7) && car_visible) ? car_mask : 8'd0;

    // Next value of each buffer row: cleared on crash exit, otherwise shifted on a strobe
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_row
            if (gi == 0) begin : g_head
                assign row_buf_next[gi] = hit_exit ? 8'd0 :
                                          (shift_en ? bus.ROW_IN : row_buf_reg[gi]);
            end else begin : g_tail
                assign row_buf_next[gi] = hit_exit ? 8'd0 :
                                          (shift_en ? row_buf_reg[gi-1] : row_buf_reg[gi]);
            end
        end
    endgenerate

    // Screen buffer registers
    always_ff @(posedge CLK) begin
        for (int i = 0; i < 8; i++) begin
            if (RESET) begin
                row_buf_reg[i] <= 8'd0;
            end else begin
                row_buf_reg[i] <= row_buf_next[i];
            end
        end
    end

    // Game FSM: crash detection, lives, crash pulse, HIT timer and game-over flag
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg     <= PLAY;
            hit_cnt_reg   <= '0;
            crash_reg     <= 1'b0;
            lives_reg     <= LIVES_INIT;
            game_over_reg <= 1'b0;
        end else begin
            crash_reg <= 1'b0;
            case (state_reg)
                PLAY: begin
                    if (hit_now) begin
                        crash_reg   <= 1'b1;
                        lives_reg   <= lives_reg - 2'd1;
                        hit_cnt_reg <= '0;
                        if (lives_reg == 2'd1) begin
                            state_reg     <= OVER;
                            game_over_reg <= 1'b1;
                        end else begin
                            state_reg <= HIT;
                        end
                    end
                end
                HIT: begin
                    if (hit_exit) begin
                        state_reg   <= PLAY;
                        hit_cnt_reg <= '0;
                    end else begin
                        hit_cnt_reg <= hit_cnt_reg + 1'b1;
                    end
                end
                OVER: begin
                    game_over_reg <= 1'b1;
                end
                default: begin
                    state_reg <= PLAY;
                end
            endcase
        end
    end

    // Car position: saturating moves while playing, re-centred after a crash.
    // Conflicting buttons cancel; the crash cycle itself does not move the car.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            car_pos_reg <= CAR_INIT;
        end else if (hit_exit) begin
            car_pos_reg <= CAR_INIT;
        end else if (is_play && !hit_now) begin
            if (bus.CAR_LEFT && !bus.CAR_RIGHT && (car_pos_reg != 3'd0)) begin
                car_pos_reg <= car_pos_reg - 3'd1;
            end else if (bus.CAR_RIGHT && !bus.CAR_LEFT && (car_pos_reg != 3'd7)) begin
                car_pos_reg <= car_pos_reg + 3'd1;
            end
        end
    end

    // Score: one point per row survived while playing, saturating
    always_ff @(posedge CLK) begin
        if (RESET) begin
            score_reg <= 8'd0;
        end else if (is_play && bus.ROW_VALID && !hit_now && (score_reg != 8'hFF)) begin
            score_reg <= score_reg + 8'd1;
        end
    end

    // Row scan: divider paces the row step, LIN and COL are registered from the same scan row
    always_ff @(posedge CLK) begin
        if (RESET) begin
            div_reg  <= '0;
            scan_reg <= 3'd0;
            lin_reg  <= 8'h01;
            col_reg  <= 8'h00;
        end else begin
            if (div_reg == DIV_LAST) begin
                div_reg  <= '0;
                scan_reg <= scan_reg + 3'd1;
            end else begin
                div_reg <= div_reg + 1'b1;
            end
            lin_reg <= 8'd1 << scan_reg;
            col_reg <= scan_row | overlay;
        end
    end

    assign bus.LIN        = lin_reg;
    assign bus.COL        = col_reg;
    assign bus.CRASH      = crash_reg;
    assign bus.LIVES_LEFT = lives_reg;
    assign bus.SCORE      = score_reg;
    assign bus.GAME_OVER  = game_over_reg;

endmodule
